// File: rtl/paddle_button_cond.sv
// Per-button sync, debounce, press/auto-repeat/release pulse generation for the paddle buttons.
// Auto-repeat is enabled only when BTN_AUTOREPEAT_EN is defined; otherwise one press pulse per accepted press.
module paddle_button_cond #(
    parameter int unsigned NUM_BTN       = 4,
    parameter int unsigned DEBOUNCE_CYC  = 1000000,
    parameter int unsigned REPEAT_DELAY  = 30000000,
    parameter int unsigned REPEAT_PERIOD = 10000000,
    parameter int unsigned CNT_W         = 28
) (
    input  logic               sysclk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release
);

    localparam int unsigned NUM_PAIR = NUM_BTN / 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        REPEAT = 2'd2
    } state_t;

    logic [NUM_BTN-1:0] r_sync1;
    logic [NUM_BTN-1:0] r_sync2;
    logic [NUM_BTN-1:0] r_level;
    logic [NUM_BTN-1:0] r_press;
    logic [NUM_BTN-1:0] r_release;
    logic [CNT_W-1:0]   r_db_cnt [NUM_BTN];
    state_t             r_state  [NUM_BTN];

    logic [NUM_BTN-1:0] w_level_nxt;
    logic [NUM_BTN-1:0] w_press_raw;
    logic [NUM_BTN-1:0] w_press_nxt;
    logic [NUM_BTN-1:0] w_release_nxt;
    logic [NUM_BTN-1:0] w_hit;
    logic [CNT_W-1:0]   w_db_cnt_nxt [NUM_BTN];
    state_t             w_state_nxt  [NUM_BTN];

`ifdef BTN_AUTOREPEAT_EN
    logic [CNT_W-1:0]   r_rep_cnt     [NUM_BTN];
    logic [CNT_W-1:0]   w_rep_cnt_nxt [NUM_BTN];
`endif

    // Debounce, per-button FSM and pair-conflict masking
    always_comb begin
        w_level_nxt   = r_level;
        w_press_raw   = '0;
        w_press_nxt   = '0;
        w_release_nxt = '0;
        w_hit         = '0;
        for (int i = 0; i < int'(NUM_BTN); i++) begin
            w_db_cnt_nxt[i] = '0;
            w_state_nxt[i]  = r_state[i];
`ifdef BTN_AUTOREPEAT_EN
            w_rep_cnt_nxt[i] = r_rep_cnt[i];
`endif
            if (r_sync2[i] != r_level[i]) begin
                if (r_db_cnt[i] == CNT_W'(DEBOUNCE_CYC - 1)) begin
                    w_hit[i]       = 1'b1;
                    w_level_nxt[i] = r_sync2[i];
                end else begin
                    w_db_cnt_nxt[i] = r_db_cnt[i] + CNT_W'(1);
                end
            end

            case (r_state[i])
                IDLE: begin
                    if (w_hit[i] && r_sync2[i]) begin
                        w_state_nxt[i] = HELD;
                        w_press_raw[i] = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                        w_rep_cnt_nxt[i] = '0;
`endif
                    end
                end
                HELD, REPEAT: begin
                    if (w_hit[i] && !r_sync2[i]) begin
                        w_state_nxt[i]   = IDLE;
                        w_release_nxt[i] = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                        w_rep_cnt_nxt[i] = '0;
                    end else if ((r_state[i] == HELD &&
                                  r_rep_cnt[i] == CNT_W'(REPEAT_DELAY - 1)) ||
                                 (r_state[i] == REPEAT &&
                                  r_rep_cnt[i] == CNT_W'(REPEAT_PERIOD - 1))) begin
                        w_state_nxt[i]   = REPEAT;
                        w_press_raw[i]   = 1'b1;
                        w_rep_cnt_nxt[i] = '0;
                    end else begin
                        w_rep_cnt_nxt[i] = r_rep_cnt[i] + CNT_W'(1);
`endif
                    end
                end
                default: w_state_nxt[i] = IDLE;
            endcase
        end

        // Holding both directions of one player blocks that player's pulses
        for (int p = 0; p < int'(NUM_PAIR); p++) begin
            if (!(w_level_nxt[2*p] && w_level_nxt[2*p+1])) begin
                w_press_nxt[2*p]   = w_press_raw[2*p];
                w_press_nxt[2*p+1] = w_press_raw[2*p+1];
            end
        end
    end

    // State and output registers
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_level   <= '0;
            r_press   <= '0;
            r_release <= '0;
            for (int i = 0; i < int'(NUM_BTN); i++) begin
                r_db_cnt[i] <= '0;
                r_state[i]  <= IDLE;
`ifdef BTN_AUTOREPEAT_EN
                r_rep_cnt[i] <= '0;
`endif
            end
        end else begin
            r_sync1   <= btn_raw;
            r_sync2   <= r_sync1;
            r_level   <= w_level_nxt;
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
            for (int i = 0; i < int'(NUM_BTN); i++) begin
                r_db_cnt[i] <= w_db_cnt_nxt[i];
                r_state[i]  <= w_state_nxt[i];
`ifdef BTN_AUTOREPEAT_EN
                r_rep_cnt[i] <= w_rep_cnt_nxt[i];
`endif
            end
        end
    end

    assign btn_level   = r_level;
    assign btn_press   = r_press;
    assign btn_release = r_release;

endmodule

// File: tb/tb_paddle_button_cond.sv
// Directed bench for paddle_button_cond with DEBOUNCE_CYC=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
// Edge k means the k-th rising edge after reset release; inputs change 1 ns after edge k.
module tb_paddle_button_cond;

    logic       sysclk = 1'b0;
    logic       rst;
    logic [3:0] btn_raw;
    logic [3:0] btn_level;
    logic [3:0] btn_press;
    logic [3:0] btn_release;

    int checks   = 0;
    int failures = 0;
    int edge_n   = 0;

    always #5 sysclk = ~sysclk;

    paddle_button_cond #(
        .NUM_BTN      (4),
        .DEBOUNCE_CYC (4),
        .REPEAT_DELAY (10),
        .REPEAT_PERIOD(3),
        .CNT_W        (8)
    ) dut (
        .sysclk     (sysclk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s edge=%0d got=%0h exp=%0h", tag, edge_n, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [3:0] el, input logic [3:0] ep,
                              input logic [3:0] er);
        check({tag, "_level"},   32'(btn_level),   32'(el));
        check({tag, "_press"},   32'(btn_press),   32'(ep));
        check({tag, "_release"}, 32'(btn_release), 32'(er));
    endtask

    task automatic step();
        @(posedge sysclk);
        #1;
        edge_n++;
    endtask

    task automatic start_scn();
        btn_raw = '0;
        rst     = 1'b1;
        repeat (3) @(posedge sysclk);
        #1;
        check("in_reset_level", 32'(btn_level), 32'd0);
        check("in_reset_press", 32'(btn_press), 32'd0);
        rst    = 1'b0;
        edge_n = -1;
        step();
        check_outs("edge0", 4'b0000, 4'b0000, 4'b0000);
    endtask

    // Edges (relative to a press applied after edge 0) that carry a press pulse
    function automatic logic press_at(input int k);
`ifdef BTN_AUTOREPEAT_EN
        return (k == 6 || k == 16 || k == 19 || k == 22 || k == 25 ||
                k == 28 || k == 31 || k == 34);
`else
        return (k == 6);
`endif
    endfunction

    initial begin
        // Clean press on button 0
        start_scn();
        btn_raw[0] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            check_outs("clean", {3'b000, k >= 6}, {3'b000, k == 6}, 4'b0000);
        end

        // Three-cycle glitch on button 1
        start_scn();
        btn_raw[1] = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            step();
            check_outs("glitch", 4'b0000, 4'b0000, 4'b0000);
            if (k == 3) btn_raw[1] = 1'b0;
        end

        // Hold button 2 for 30 cycles, then release
        start_scn();
        btn_raw[2] = 1'b1;
        for (int k = 1; k <= 45; k++) begin
            step();
            check_outs("hold", {1'b0, k >= 6 && k < 36, 2'b00},
                       {1'b0, press_at(k), 2'b00}, {1'b0, k == 36, 2'b00});
            if (k == 30) btn_raw[2] = 1'b0;
        end

        // Both buttons of player 1 together
        start_scn();
        btn_raw[1:0] = 2'b11;
        for (int k = 1; k <= 32; k++) begin
            step();
            check_outs("pair", {2'b00, {2{k >= 6 && k < 26}}}, 4'b0000,
                       {2'b00, {2{k == 26}}});
            if (k == 20) btn_raw[1:0] = 2'b00;
        end

        // Reset during a hold of button 3
        start_scn();
        btn_raw[3] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            check_outs("prerst", {k >= 6, 3'b000}, {k == 6, 3'b000}, 4'b0000);
        end
        rst = 1'b1;
        #1;
        check_outs("rst_async", 4'b0000, 4'b0000, 4'b0000);
        for (int k = 13; k <= 14; k++) begin
            step();
            check_outs("rst_held", 4'b0000, 4'b0000, 4'b0000);
        end
        rst = 1'b0;
        for (int k = 15; k <= 24; k++) begin
            step();
            check_outs("postrst", {k >= 20, 3'b000}, {k == 20, 3'b000}, 4'b0000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
